// File: rtl/ofdm_src_pkg.sv
// Shared constants, state encoding and output beat type for the OFDM TX byte source.
package ofdm_src_pkg;

  localparam int unsigned DATA_W          = 8;
  localparam int unsigned BITS_PER_SYM    = 4;
  localparam int unsigned N_SC            = 8;
  localparam int unsigned FRAME_BYTES_DEF = N_SC * BITS_PER_SYM / 8;
  localparam int unsigned CNT_W           = 8;

  // PRBS-15, x^15 + x^14 + 1: output and feedback taps
  localparam int unsigned PRBS_W          = 15;
  localparam int unsigned PRBS_TAP_A      = 14;
  localparam int unsigned PRBS_TAP_B      = 13;
  localparam logic [PRBS_W-1:0] PRBS_SEED_DEF = 15'h7FFF;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } src_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              valid;
  } src_beat_t;

endpackage

// File: rtl/src_prbs15_byte.sv
// Advances a Fibonacci PRBS-15 register by eight steps, producing one byte MSB first.
module src_prbs15_byte
  import ofdm_src_pkg::*;
(
  input  logic [PRBS_W-1:0] state_in,
  output logic [PRBS_W-1:0] state_out,
  output logic [DATA_W-1:0] byte_out
);

  logic [PRBS_W-1:0] s;

  always_comb begin
    s        = state_in;
    byte_out = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      byte_out[DATA_W-1-i] = s[PRBS_TAP_A];
      s = {s[PRBS_W-2:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
    end
    state_out = s;
  end

endmodule

// File: rtl/source_gen1.sv
// Framed byte test source (PRBS-15 or counter) with valid/ready output and optional inter-frame gap.
module source_gen1
  import ofdm_src_pkg::*;
#(
  parameter int unsigned       MODE        = 1,
  parameter logic [PRBS_W-1:0] SEED        = PRBS_SEED_DEF,
  parameter int unsigned       FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int unsigned       IDLE_GAP    = 0
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = (IDLE_GAP == 0) ? '0 : CNT_W'(IDLE_GAP - 1);

  if (SEED == '0) begin : g_seed_chk
    $error("source_gen1: SEED must be non-zero");
  end
  if (FRAME_BYTES < 1 || FRAME_BYTES > 255) begin : g_frame_chk
    $error("source_gen1: FRAME_BYTES out of range 1..255");
  end
  if (IDLE_GAP > 255) begin : g_gap_chk
    $error("source_gen1: IDLE_GAP out of range 0..255");
  end

  src_state_e        state_q, state_d;
  logic [PRBS_W-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              armed_q, armed_d;
  src_beat_t         beat_q, beat_d;

  logic [PRBS_W-1:0] prbs_next;
  logic [DATA_W-1:0] prbs_byte;
  logic [DATA_W-1:0] gen_byte;
  logic              xfer;
  logic              advance;

  src_prbs15_byte u_prbs (
    .state_in  (lfsr_q),
    .state_out (prbs_next),
    .byte_out  (prbs_byte)
  );

  assign gen_byte = (MODE == 0) ? cnt_q : prbs_byte;
  assign xfer     = beat_q.valid && ready;
  assign data     = beat_q.data;
  assign valid    = beat_q.valid;

  // Next-state, counters and output register inputs
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    armed_d    = armed_q;
    beat_d     = beat_q;
    advance    = 1'b0;

    case (state_q)
      LOAD: begin
        // one settling cycle after reset, so valid first rises on the second edge
        if (!armed_q) begin
          armed_d = 1'b1;
        end else begin
          beat_d.data  = gen_byte;
          beat_d.valid = 1'b1;
          advance      = 1'b1;
          state_d      = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (byte_cnt_q == LAST_IDX) begin
            byte_cnt_d = '0;
            if (IDLE_GAP > 0) begin
              // generator is left untouched; LOAD fetches the next byte
              beat_d.valid = 1'b0;
              state_d      = GAP;
            end else begin
              beat_d.data = gen_byte;
              advance     = 1'b1;
            end
          end else begin
            byte_cnt_d  = byte_cnt_q + CNT_W'(1);
            beat_d.data = gen_byte;
            advance     = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = LOAD;
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = LOAD;
    endcase

    if (advance) begin
      lfsr_d = prbs_next;
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!reset) begin
      state_q    <= LOAD;
      lfsr_q     <= SEED;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      armed_q    <= 1'b0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      armed_q    <= armed_d;
      beat_q     <= beat_d;
    end
  end

endmodule

// File: tb/tb_source_gen1.sv
// Directed bench for source_gen1: PRBS, counter, backpressure, idle gap and reset cases.
`timescale 1ns/1ps
module tb_source_gen1;

  logic       aclk = 1'b0;
  logic       reset = 1'b0;
  logic       ready_p = 1'b0;
  logic       ready_c = 1'b1;
  logic       ready_g = 1'b1;
  logic [7:0] data_p, data_c, data_g;
  logic       valid_p, valid_c, valid_g;

  int n_vec = 0;
  int n_err = 0;
  logic [14:0] gm_state;

  always #5 aclk = ~aclk;

  source_gen1 #(.MODE(1), .SEED(15'h7FFF), .FRAME_BYTES(4), .IDLE_GAP(0)) dut_p (
    .aclk(aclk), .reset(reset), .ready(ready_p), .data(data_p), .valid(valid_p));

  source_gen1 #(.MODE(0), .SEED(15'h7FFF), .FRAME_BYTES(4), .IDLE_GAP(0)) dut_c (
    .aclk(aclk), .reset(reset), .ready(ready_c), .data(data_c), .valid(valid_c));

  source_gen1 #(.MODE(1), .SEED(15'h7FFF), .FRAME_BYTES(4), .IDLE_GAP(3)) dut_g (
    .aclk(aclk), .reset(reset), .ready(ready_g), .data(data_g), .valid(valid_g));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic gm_reset();
    gm_state = 15'h7FFF;
  endtask

  // bit-serial PRBS-15 reference, MSB of the byte is the first bit out
  task automatic gm_next(output logic [7:0] b);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      b[7-i]   = gm_state[14];
      fb       = gm_state[14] ^ gm_state[13];
      gm_state = {gm_state[13:0], fb};
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) step();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] exp;
    logic       r;
    logic       exp_v;

    // reset state and PRBS stream start
    ready_p = 1'b0;
    reset   = 1'b0;
    repeat (10) begin
      step();
      chk("rst_valid", 32'(valid_p), 32'd0);
    end
    chk("rst_data", 32'(data_p), 32'h00);
    reset   = 1'b1;
    ready_p = 1'b1;
    gm_reset();
    step();
    chk("edge1_valid", 32'(valid_p), 32'd0);
    step();
    chk("edge2_valid", 32'(valid_p), 32'd1);
    chk("first_ff", 32'(data_p), 32'hFF);
    gm_next(b);
    for (int i = 1; i < 50; i++) begin
      step();
      gm_next(b);
      chk("prbs_data", 32'(data_p), 32'(b));
      chk("prbs_valid", 32'(valid_p), 32'd1);
    end

    // counter mode, including wrap
    do_reset(3);
    step();
    step();
    chk("cnt_first", 32'(data_c), 32'h00);
    chk("cnt_valid", 32'(valid_c), 32'd1);
    for (int i = 1; i <= 256; i++) begin
      step();
      chk("cnt_data", 32'(data_c), 32'(i % 256));
    end

    // idle gap framing: 4 valid, 4 idle (3 gap + LOAD)
    do_reset(3);
    gm_reset();
    step();
    for (int k = 0; k < 24; k++) begin
      step();
      exp_v = ((k % 8) < 4);
      chk("gap_valid", 32'(valid_g), 32'(exp_v));
      if (exp_v) begin
        gm_next(b);
        chk("gap_data", 32'(data_g), 32'(b));
      end
    end

    // reset mid-frame
    ready_p = 1'b1;
    do_reset(3);
    step();
    step();
    chk("mid_b0", 32'(data_p), 32'hFF);
    step();
    chk("mid_b1", 32'(data_p), 32'hFE);
    step();
    reset = 1'b0;
    step();
    chk("mid_rst_valid", 32'(valid_p), 32'd0);
    chk("mid_rst_data", 32'(data_p), 32'h00);
    step();
    reset = 1'b1;
    step();
    chk("mid_rel_valid", 32'(valid_p), 32'd0);
    step();
    chk("mid_restart", 32'(data_p), 32'hFF);
    chk("mid_restart_v", 32'(valid_p), 32'd1);

    // ready low through LOAD: first byte held, then exactly one transfer
    ready_p = 1'b0;
    do_reset(3);
    step();
    step();
    chk("hold_valid", 32'(valid_p), 32'd1);
    chk("hold_ff", 32'(data_p), 32'hFF);
    repeat (4) begin
      step();
      chk("hold_ff_stay", 32'(data_p), 32'hFF);
      chk("hold_valid_stay", 32'(valid_p), 32'd1);
    end
    ready_p = 1'b1;
    step();
    chk("hold_one_xfer", 32'(data_p), 32'hFE);
    ready_p = 1'b0;
    step();
    chk("hold_after", 32'(data_p), 32'hFE);

    // random backpressure against the golden sequence
    ready_p = 1'b0;
    do_reset(3);
    gm_reset();
    step();
    step();
    gm_next(exp);
    chk("bp_first", 32'(data_p), 32'(exp));
    for (int i = 0; i < 200; i++) begin
      r = 1'($urandom_range(0, 1));
      ready_p = r;
      step();
      if (r) gm_next(exp);
      chk("bp_data", 32'(data_p), 32'(exp));
      chk("bp_valid", 32'(valid_p), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
